// File: rtl/ddr4_pkg.sv
// Shared definitions for the DDR4 request front-end: controller state codes,
// address field positions, request record and queue FSM states.
package ddr4_pkg;

  localparam logic [2:0] CS_INIT0   = 3'd0;
  localparam logic [2:0] CS_INIT1   = 3'd1;
  localparam logic [2:0] CS_INIT2   = 3'd2;
  localparam logic [2:0] CS_INIT3   = 3'd3;
  localparam logic [2:0] CS_WAITING = 3'd4;
  localparam logic [2:0] CS_IDLE    = 3'd5;
  localparam logic [2:0] CS_READ    = 3'd6;
  localparam logic [2:0] CS_WRITE   = 3'd7;

  localparam int BG_MSB  = 30;
  localparam int BG_LSB  = 29;
  localparam int BA_MSB  = 28;
  localparam int BA_LSB  = 27;
  localparam int ROW_MSB = 26;
  localparam int ROW_LSB = 10;
  localparam int COL_MSB = 9;
  localparam int COL_LSB = 0;

  localparam int REQ_AW = 31;
  localparam int REQ_DW = 4;

  typedef struct packed {
    logic              we;
    logic [REQ_AW-1:0] addr;
    logic [REQ_DW-1:0] wdat;
  } req_t;

  typedef enum logic [1:0] {
    Q_EMPTY   = 2'd0,
    Q_PRESENT = 2'd1,
    Q_WAIT    = 2'd2
  } qstate_e;

endpackage

// File: rtl/ddr4_req_fifo.sv
// Request storage: power-of-two ring buffer with naturally wrapping pointers,
// occupancy count and full/empty flags. Head entry is read combinationally.
module ddr4_req_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      level_q <= level_q + LW'(push) - LW'(pop);
    end
  end

  assign rdata = mem_q[rptr_q];
  assign level = level_q;
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

endmodule

// File: rtl/ddr4_req_queue.sv
// Host request queue in front of the DDR4 controller; presents one request at a
// time and pops it once the controller issues it. Optional DDR4_REQ_STATS_EN.
module ddr4_req_queue
  import ddr4_pkg::*;
#(
  parameter int         DEPTH    = 8,
  parameter int         AW       = 31,
  parameter int         DW       = 4,
  parameter logic [2:0] ST_IDLE  = CS_IDLE,
  parameter logic [2:0] ST_READ  = CS_READ,
  parameter logic [2:0] ST_WRITE = CS_WRITE,
  parameter int         TMO      = 4096
) (
  input  logic                   clkin,
  input  logic                   crst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [AW-1:0]          req_addr,
  input  logic [DW-1:0]          req_wdat,
  output logic                   crd,
  output logic                   cwr,
  output logic [AW-1:0]          ca,
  output logic [DW-1:0]          cwdat,
  input  logic [2:0]             curr_state,
  output logic                   done_valid,
  output logic                   done_we,
  output logic [$clog2(DEPTH):0] level,
  output logic                   stall_err
`ifdef DDR4_REQ_STATS_EN
  ,
  output logic [31:0]            rd_count,
  output logic [31:0]            wr_count
`endif
);
  localparam int TCW = $clog2(TMO + 1);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdat;
  } ent_t;

  ent_t    head, wr_ent;
  logic    push, pop, load, full, empty;
  qstate_e state_q, state_d;

  logic          crd_q, crd_d, cwr_q, cwr_d;
  logic [AW-1:0] ca_q, ca_d;
  logic [DW-1:0] cwdat_q, cwdat_d;
  logic          done_q, done_d, done_we_q, done_we_d, pend_we_q, pend_we_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic          stall_q, stall_d;

  assign wr_ent = '{we: req_we, addr: req_addr, wdat: req_wdat};
  assign push   = req_valid && !full;

  ddr4_req_fifo #(.DEPTH(DEPTH), .W($bits(ent_t))) u_fifo (
    .clk   (clkin),
    .rst   (crst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_ent),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d   = state_q;
    crd_d     = crd_q;
    cwr_d     = cwr_q;
    ca_d      = ca_q;
    cwdat_d   = cwdat_q;
    pend_we_d = pend_we_q;
    done_d    = 1'b0;
    done_we_d = done_we_q;
    pop       = 1'b0;
    load      = 1'b0;
    case (state_q)
      Q_EMPTY: begin
        if (!empty) begin
          load    = 1'b1;
          state_d = Q_PRESENT;
        end
      end
      Q_PRESENT: begin
        if (curr_state == ST_READ || curr_state == ST_WRITE) begin
          pop       = 1'b1;
          pend_we_d = head.we;
          crd_d     = 1'b0;
          cwr_d     = 1'b0;
          state_d   = Q_WAIT;
        end
      end
      Q_WAIT: begin
        if (curr_state == ST_IDLE) begin
          done_d    = 1'b1;
          done_we_d = pend_we_q;
          if (!empty) begin
            load    = 1'b1;
            state_d = Q_PRESENT;
          end else begin
            state_d = Q_EMPTY;
          end
        end
      end
      default: state_d = Q_EMPTY;
    endcase
    if (load) begin
      crd_d   = ~head.we;
      cwr_d   = head.we;
      ca_d    = head.addr;
      cwdat_d = head.wdat;
    end
  end

  // Stall timer restarts with every new presentation and saturates at TMO.
  always_comb begin
    tmo_d = tmo_q;
    if (load)
      tmo_d = '0;
    else if (state_q == Q_PRESENT && tmo_q != TCW'(TMO))
      tmo_d = tmo_q + TCW'(1);
    stall_d = stall_q || (tmo_d == TCW'(TMO));
  end

  always_ff @(posedge clkin) begin
    if (crst) begin
      state_q   <= Q_EMPTY;
      crd_q     <= 1'b0;
      cwr_q     <= 1'b0;
      ca_q      <= '0;
      cwdat_q   <= '0;
      done_q    <= 1'b0;
      done_we_q <= 1'b0;
      pend_we_q <= 1'b0;
      tmo_q     <= '0;
      stall_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      crd_q     <= crd_d;
      cwr_q     <= cwr_d;
      ca_q      <= ca_d;
      cwdat_q   <= cwdat_d;
      done_q    <= done_d;
      done_we_q <= done_we_d;
      pend_we_q <= pend_we_d;
      tmo_q     <= tmo_d;
      stall_q   <= stall_d;
    end
  end

  assign req_ready  = !full;
  assign crd        = crd_q;
  assign cwr        = cwr_q;
  assign ca         = ca_q;
  assign cwdat      = cwdat_q;
  assign done_valid = done_q;
  assign done_we    = done_we_q;
  assign stall_err  = stall_q;

`ifdef DDR4_REQ_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  // Counted on the same edge that raises done_valid.
  always_ff @(posedge clkin) begin
    if (crst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (done_d) begin
      if (done_we_d) wr_cnt_q <= wr_cnt_q + 32'd1;
      else           rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_ddr4_req_queue.sv
// Randomized bench for ddr4_req_queue against a queue-based reference model;
// directed segments first, then free-running random traffic and resets.
module tb_ddr4_req_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 31;
  localparam int DW    = 4;
  localparam int TMO   = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clkin = 1'b0;
  logic          crst = 1'b1;
  logic          req_valid = 1'b0, req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdat = '0;
  logic [2:0]    curr_state = 3'd5;
  logic          req_ready, crd, cwr, done_valid, done_we, stall_err;
  logic [AW-1:0] ca;
  logic [DW-1:0] cwdat;
  logic [LW-1:0] level;
`ifdef DDR4_REQ_STATS_EN
  logic [31:0]   rd_count, wr_count;
`endif

  always #5 clkin = ~clkin;

  ddr4_req_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clkin(clkin), .crst(crst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdat(req_wdat),
    .crd(crd), .cwr(cwr), .ca(ca), .cwdat(cwdat), .curr_state(curr_state),
    .done_valid(done_valid), .done_we(done_we), .level(level), .stall_err(stall_err)
`ifdef DDR4_REQ_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a list of outstanding requests plus what the controller
  // currently sees. 0 = nothing shown, 1 = showing head, 2 = head issued.
  typedef struct { bit we; logic [AW-1:0] a; logic [DW-1:0] d; } mreq_t;
  mreq_t q[$];
  int    phase = 0;
  bit    m_crd, m_cwr, m_done, m_done_we, m_stall, m_issued_we;
  logic [AW-1:0] m_ca;
  logic [DW-1:0] m_cwdat;
  int    m_wait;
  int    m_rd, m_wr;

  function automatic void show_head();
    m_crd   = !q[0].we;
    m_cwr   = q[0].we;
    m_ca    = q[0].a;
    m_cwdat = q[0].d;
    m_wait  = 0;
    phase   = 1;
  endfunction

  function automatic void model_step();
    bit    accept;
    mreq_t r;
    if (crst) begin
      q.delete();
      phase = 0; m_crd = 0; m_cwr = 0; m_ca = '0; m_cwdat = '0;
      m_done = 0; m_done_we = 0; m_stall = 0; m_issued_we = 0; m_wait = 0;
      m_rd = 0; m_wr = 0;
      return;
    end
    accept = req_valid && (q.size() != DEPTH);
    m_done = 0;
    if (phase == 0) begin
      if (q.size() > 0) show_head();
    end else if (phase == 1) begin
      if (m_wait < TMO) m_wait++;
      if (m_wait == TMO) m_stall = 1;
      if (curr_state == 3'd6 || curr_state == 3'd7) begin
        m_issued_we = q[0].we;
        void'(q.pop_front());
        m_crd = 0; m_cwr = 0;
        phase = 2;
      end
    end else begin
      if (curr_state == 3'd5) begin
        m_done = 1;
        m_done_we = m_issued_we;
        if (m_issued_we) m_wr++; else m_rd++;
        if (q.size() > 0) show_head(); else phase = 0;
      end
    end
    if (accept) begin
      r.we = req_we; r.a = req_addr; r.d = req_wdat;
      q.push_back(r);
    end
  endfunction

  task automatic check_all();
    chk("level", 64'(level), 64'(q.size()));
    chk("req_ready", 64'(req_ready), 64'(q.size() != DEPTH));
    chk("crd", 64'(crd), 64'(m_crd));
    chk("cwr", 64'(cwr), 64'(m_cwr));
    chk("ca", 64'(ca), 64'(m_ca));
    chk("cwdat", 64'(cwdat), 64'(m_cwdat));
    chk("done_valid", 64'(done_valid), 64'(m_done));
    chk("done_we", 64'(done_we), 64'(m_done_we));
    chk("stall_err", 64'(stall_err), 64'(m_stall));
`ifdef DDR4_REQ_STATS_EN
    chk("rd_count", 64'(rd_count), 64'(m_rd));
    chk("wr_count", 64'(wr_count), 64'(m_wr));
`endif
  endtask

  task automatic cyc(input bit r, input bit v, input bit w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [2:0] cs);
    @(negedge clkin);
    crst = r; req_valid = v; req_we = w; req_addr = a; req_wdat = d; curr_state = cs;
    @(posedge clkin);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input logic [2:0] cs);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, cs);
  endtask

  function automatic logic [2:0] rand_cs();
    int k;
    k = $urandom_range(0, 9);
    if (k < 2) return 3'd4;
    if (k < 5) return 3'd5;
    if (k < 7) return 3'd6;
    if (k < 9) return 3'd7;
    return 3'($urandom_range(0, 3));
  endfunction

  initial begin
    int ndone;
    // reset state
    cyc(1'b1, 1'b0, 1'b0, '0, '0, 3'd5);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, 3'd5);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_crd_cwr", 64'({crd, cwr}), 64'd0);

    // single read end to end
    cyc(1'b0, 1'b1, 1'b0, 31'h0000_0400, 4'h0, 3'd5);
    idle(3'd5);
    chk("rd_crd", 64'(crd), 64'd1);
    chk("rd_ca", 64'(ca), 64'h400);
    idle(3'd6);
    chk("rd_pop_level", 64'(level), 64'd0);
    idle(3'd5);
    chk("rd_done", 64'({done_valid, done_we}), 64'b10);
    idle(3'd5);
    chk("rd_done_pulse", 64'(done_valid), 64'd0);

    // fill with writes, then drain while pushing on pop cycles
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b0, 1'b1, 1'b1, 31'($urandom), 4'(i + 3), 3'd4);
    chk("full_level", 64'(level), 64'(DEPTH));
    chk("full_ready", 64'(req_ready), 64'd0);
    ndone = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      cyc(1'b0, i < 3, 1'b0, 31'($urandom), 4'($urandom), 3'd7);
      idle(3'd5);
      ndone += done_valid;
    end
    chk("drain_done_cnt", 64'(ndone), 64'(DEPTH + 2));

    // long wait state while presenting, then stall timeout
    cyc(1'b1, 1'b0, 1'b0, '0, '0, 3'd5);
    cyc(1'b0, 1'b1, 1'b1, 31'h1234_5678, 4'hA, 3'd4);
    for (int i = 0; i < 20; i++) idle(3'd4);
    chk("hold_cwr", 64'(cwr), 64'd1);
    chk("hold_ca", 64'(ca), 64'h1234_5678);
    chk("hold_stall", 64'(stall_err), 64'd1);
    idle(3'd7);
    idle(3'd4);
    idle(3'd5);
    chk("hold_done", 64'({done_valid, done_we}), 64'b11);
    idle(3'd5);
    chk("stall_sticky", 64'(stall_err), 64'd1);

    // reset while an issued request is pending with 3 more queued
    cyc(1'b1, 1'b0, 1'b0, '0, '0, 3'd5);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'($urandom), 31'($urandom), 4'($urandom), 3'd4);
    idle(3'd6);
    idle(3'd4);
    chk("wait_level", 64'(level), 64'd3);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, 3'd4);
    chk("rstw_level", 64'(level), 64'd0);
    chk("rstw_crd_cwr", 64'({crd, cwr}), 64'd0);
    idle(3'd5);
    chk("rstw_no_done", 64'(done_valid), 64'd0);

    // stats: 3 reads and 2 writes completed from a clean start
    cyc(1'b1, 1'b0, 1'b0, '0, '0, 3'd5);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, i >= 3, 31'($urandom), 4'($urandom), 3'd5);
      idle(3'd5);
      idle(3'd6);
      idle(3'd5);
    end
`ifdef DDR4_REQ_STATS_EN
    chk("stat_rd", 64'(rd_count), 64'd3);
    chk("stat_wr", 64'(wr_count), 64'd2);
`endif

    // random traffic
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, 1'($urandom),
          31'($urandom), 4'($urandom), rand_cs());

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
